// File: rtl/msrv32_pkg.sv
// ---------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the write-back stage:
//   - WB_SEL result-source encodings (WB_ALU, WB_LOAD, WB_IMM, WB_PC4, WB_CSR)
//   - load funct3 constants (LB, LH, LW, LBU, LHU)
//   - write-back FSM state encoding (ST_IDLE, ST_WAIT_MEM)
//   - is_misaligned(): detects halfword/word loads whose offset breaks alignment
// ---------------------------------------------------------------------------
package msrv32_pkg;

  // Result-source select encodings; unlisted codes fall back to the ALU.
  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_LOAD = 3'd1;
  localparam logic [2:0] WB_IMM  = 3'd2;
  localparam logic [2:0] WB_PC4  = 3'd3;
  localparam logic [2:0] WB_CSR  = 3'd4;

  // Load funct3 encodings; 011/110/111 are reserved and read as a full word.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  // Halfword loads need off[0]==0; word loads need off==0.
  // Byte and reserved loads can never be misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (funct3)
      LH, LHU: mis = off[0];
      LW:      mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// ---------------------------------------------------------------------------
// msrv32_load_align
// Combinational load data aligner: picks the addressed byte/halfword out of a
// word-aligned memory read and sign- or zero-extends it to XLEN.
// Ports:
//   funct3   in   3     load type
//   offset   in   2     byte offset within the word
//   rdata    in   XLEN  word-aligned memory read data
//   ext_data out  XLEN  aligned, extended load result
// ---------------------------------------------------------------------------
module msrv32_load_align
  import msrv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  // Only offset[1] picks the halfword; a set offset[0] is simply ignored here.
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ext_data = rdata;
    case (funct3)
      LB:      ext_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU:     ext_data = {{(XLEN-8){1'b0}}, byte_sel};
      LH:      ext_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LHU:     ext_data = {{(XLEN-16){1'b0}}, half_sel};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/msrv32_wb_unit.sv
// ---------------------------------------------------------------------------
// msrv32_wb_unit
// Write-back stage driving the integer register file write port. Non-load
// results are written one cycle after acceptance; loads park in WAIT_MEM
// until the data memory returns data, which is then aligned and written.
// Optional build macro: MSRV32_WB_MISALIGN_CHK_EN adds misaligned_out and
// suppresses the register write of misaligned halfword/word loads.
// Ports:
//   ms_risc32_mp_clk_in  in   clock, rising edge
//   ms_risc32_mp_rst_in  in   async active-high reset
//   valid_in / ready_out      instruction handshake with execute
//   rd_addr_in, rf_wr_en_in, wb_sel_in   destination, write flag, source
//   alu_result_in, imm_in, pc_in, csr_data_in   result candidates
//   load_funct3_in            load type
//   dmem_rdata_in, dmem_valid_in   data-memory response
//   rd_addr_out, rd_out, wr_en_out   register-file write port (registered)
//   busy_out                  high while waiting on memory
//   misaligned_out            (optional) misaligned-load pulse
// ---------------------------------------------------------------------------
module msrv32_wb_unit
  import msrv32_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int WB_SEL_W = 3
) (
  input  logic                ms_risc32_mp_clk_in,
  input  logic                ms_risc32_mp_rst_in,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic [4:0]          rd_addr_in,
  input  logic                rf_wr_en_in,
  input  logic [WB_SEL_W-1:0] wb_sel_in,
  input  logic [XLEN-1:0]     alu_result_in,
  input  logic [XLEN-1:0]     imm_in,
  input  logic [XLEN-1:0]     pc_in,
  input  logic [XLEN-1:0]     csr_data_in,
  input  logic [2:0]          load_funct3_in,
  input  logic [XLEN-1:0]     dmem_rdata_in,
  input  logic                dmem_valid_in,
  output logic [4:0]          rd_addr_out,
  output logic [XLEN-1:0]     rd_out,
  output logic                wr_en_out,
  output logic                busy_out
`ifdef MSRV32_WB_MISALIGN_CHK_EN
  ,
  output logic                misaligned_out
`endif
);

  wb_state_e state_q, state_d;

  // Load context captured at acceptance; execute moves on while we wait.
  logic [4:0]      ld_rd_addr_q;
  logic            ld_wr_en_q;
  logic [2:0]      ld_funct3_q;
  logic [1:0]      ld_off_q;
  logic            ld_capture;

  logic [4:0]      rd_addr_d;
  logic [XLEN-1:0] rd_d;
  logic            wr_en_d;
  logic [XLEN-1:0] sel_value;
  logic [XLEN-1:0] load_value;
  logic            ld_misaligned;

  assign ready_out = (state_q == ST_IDLE);
  assign busy_out  = (state_q == ST_WAIT_MEM);

  msrv32_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .funct3   (ld_funct3_q),
    .offset   (ld_off_q),
    .rdata    (dmem_rdata_in),
    .ext_data (load_value)
  );

  assign ld_misaligned = is_misaligned(ld_funct3_q, ld_off_q);

  // PC+4 wraps naturally at XLEN bits.
  always_comb begin
    sel_value = alu_result_in;
    case (wb_sel_in)
      WB_IMM:  sel_value = imm_in;
      WB_PC4:  sel_value = pc_in + XLEN'(4);
      WB_CSR:  sel_value = csr_data_in;
      default: sel_value = alu_result_in;
    endcase
  end

  always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
    if (ms_risc32_mp_rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // rd_addr_out/rd_out hold their last value between writes; wr_en_out
  // defaults low so every write is a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_out;
    rd_d       = rd_out;
    wr_en_d    = 1'b0;
    ld_capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (wb_sel_in == WB_LOAD) begin
            ld_capture = 1'b1;
            state_d    = ST_WAIT_MEM;
          end else begin
            rd_addr_d = rd_addr_in;
            rd_d      = sel_value;
            wr_en_d   = rf_wr_en_in && (rd_addr_in != 5'd0);
          end
        end
      end
      ST_WAIT_MEM: begin
        if (dmem_valid_in) begin
          state_d   = ST_IDLE;
          rd_addr_d = ld_rd_addr_q;
          rd_d      = load_value;
          wr_en_d   = ld_wr_en_q && (ld_rd_addr_q != 5'd0);
`ifdef MSRV32_WB_MISALIGN_CHK_EN
          if (ld_misaligned) begin
            wr_en_d = 1'b0;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
    if (ms_risc32_mp_rst_in) begin
      rd_addr_out <= 5'd0;
      rd_out      <= '0;
      wr_en_out   <= 1'b0;
    end else begin
      rd_addr_out <= rd_addr_d;
      rd_out      <= rd_d;
      wr_en_out   <= wr_en_d;
    end
  end

  always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
    if (ms_risc32_mp_rst_in) begin
      ld_rd_addr_q <= 5'd0;
      ld_wr_en_q   <= 1'b0;
      ld_funct3_q  <= 3'd0;
      ld_off_q     <= 2'd0;
    end else if (ld_capture) begin
      ld_rd_addr_q <= rd_addr_in;
      ld_wr_en_q   <= rf_wr_en_in;
      ld_funct3_q  <= load_funct3_in;
      ld_off_q     <= alu_result_in[1:0];
    end
  end

`ifdef MSRV32_WB_MISALIGN_CHK_EN
  // Pulses in the same cycle the suppressed write would have appeared.
  always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
    if (ms_risc32_mp_rst_in) begin
      misaligned_out <= 1'b0;
    end else begin
      misaligned_out <= (state_q == ST_WAIT_MEM) && dmem_valid_in && ld_misaligned;
    end
  end
`else
  // Without the checker, misaligned loads write normally.
  logic unused_misaligned;
  assign unused_misaligned = ld_misaligned;
`endif

endmodule
